dnn_neuron_mac: RTL
===================

Name: dnn_neuron_mac

Overview:
- Three-input fixed-point neuron that consumes the operand registers (x1..x3, w1..w3) and the per-input valid flags (done1..done3) driven by the CPU-to-DNN wiring stage.
- Computes y = act(x1*w1 + x2*w2 + x3*w3) with a single shared multiplier over three cycles.
- Returns the result on y with a one-cycle neuron_done pulse; that pulse triggers register write-back upstream.
- Drives ready, which the wiring stage uses to release the PC stall.

Parameters:
- DATA_W, 16, operand and result width, signed two's complement.
- FRAC_W, 8, fractional bits; default format is Q8.8.
- ACC_W, 36, signed accumulator width; must be at least 2*DATA_W+2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- x1, x2, x3  input  DATA_W  activation operands, signed Q8.8
- w1, w2, w3  input  DATA_W  weight operands, signed Q8.8
- done1, done2, done3  input  1  per-input valid levels; sticky, held high by the upstream stage
- y  output  DATA_W  neuron result, signed Q8.8, held until the next result
- neuron_done  output  1  single-cycle pulse when y is updated
- ready  output  1  high while idle and able to accept a new computation

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset; all state updates on the rising edge of clk.
- Reset values: y=0, neuron_done=0, ready=1, accumulator=0, operand latches=0, state=IDLE, all_q=0.
- Start detection: all_v = done1&done2&done3; all_q is the registered copy of all_v.
  - start = all_v & ~all_q & (state==IDLE).
  - A start edge occurring while not IDLE is dropped; nothing is queued.
  - Re-arm requires all_v to go low and then high again.
  - If all_v is already high when reset is released, start fires on the first clock after reset.
- FSM (one state per cycle; edge detected in cycle N):
  - IDLE: ready=1. On start, go to LOAD.
  - LOAD (N+1): latch x1..x3 and w1..w3; clear accumulator; ready=0. Latching one cycle after the edge captures a weight written in the same cycle as the last done flag.
  - MAC0 (N+2): acc += sext(x1*w1). The product is a full 2*DATA_W signed value.
  - MAC1 (N+3): acc += x2*w2.
  - MAC2 (N+4): acc += x3*w3.
  - ACT (N+5): r = acc >>> FRAC_W (arithmetic shift, truncates toward minus infinity).
    - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then apply the activation (see Optional Feature). Register the result into y.
  - DONE (N+6): neuron_done=1 for exactly this cycle; y is already valid. Next state is IDLE, where ready returns to 1 at N+7.
- Latency: edge at N gives neuron_done at N+6. ready is low for cycles N+1..N+6. Minimum issue interval is 7 cycles plus the done-low re-arm time.
- Operands may change after LOAD without affecting the computation in progress.
- y changes only in ACT or on reset; neuron_done is never high for two consecutive cycles.
- Reset asserted in any state: the next edge applies the reset values and any in-flight result is discarded, with no neuron_done.
- The accumulator never overflows: three products fit in 2*DATA_W+2 bits.

Optional Feature:
- Macro: DNN_NEURON_RELU_EN.
- Defined: in ACT, a negative saturated result is replaced by 0, so y ranges over [0, 2^(DATA_W-1)-1].
- Undefined: linear activation; y is the signed saturated result.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic sum: x=(0x0100, 0x0080, 0xFF00), w=(0x0200, 0x0400, 0x0100); raise done1/done2 at cycle 0 and done3 at cycle 3.
  - Expect ready=0 from cycle 4, neuron_done pulse at cycle 9, y=0x0300 (3.0).
- Negative result: x1=0xFE00, w1=0x0200, all others 0.
  - With RELU_EN: y=0x0000. Without: y=0xFC00 (-4.0).
- Saturation: all x=0x7F00 and all w=0x7F00.
  - Expect y=0x7FFF.
  - Build without RELU_EN, all x=0x8000, all w=0x7F00: expect y=0x8000.
- Busy ignore and re-arm: hold all done high, drop them at N+2, re-raise them at N+3.
  - Expect exactly one neuron_done (at N+6) and no second computation.
  - Then drop and re-raise the done levels after ready=1: expect a new pulse 6 cycles after the edge.
- Reset mid-operation: assert reset for 1 cycle in MAC1.
  - Expect no neuron_done, y=0, and ready=1 the cycle after reset.
  - With done levels still high, a new computation starts on the first clock after reset release, with neuron_done 6 cycles later.

Source files
------------

// File: rtl/dnn_neuron_mac.sv
// dnn_neuron_mac: three-input fixed-point neuron, y = act(x1*w1 + x2*w2 + x3*w3).
// One shared multiplier is stepped over three MAC cycles. The result is
// arithmetic-shifted by FRAC_W, saturated to DATA_W and passed through the
// activation.
// Optional macro DNN_NEURON_RELU_EN selects the activation. When it is defined,
// the activation is ReLU. When it is undefined, the activation is linear.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   x1..x3, w1..w3      signed Q(DATA_W-FRAC_W).FRAC_W operands
//   done1..done3        sticky per-input valid levels; their joint rising edge starts a run
//   y                   registered result, held until the next result
//   neuron_done         one-cycle pulse in the cycle y becomes valid
//   ready               high while idle and able to accept a new computation
module dnn_neuron_mac #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned ACC_W  = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2,
    input  logic [DATA_W-1:0] w3,
    input  logic              done1,
    input  logic              done2,
    input  logic              done3,
    output logic [DATA_W-1:0] y,
    output logic              neuron_done,
    output logic              ready
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    // Saturation bounds expressed in the accumulator domain
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MAC0 = 3'd2,
        MAC1 = 3'd3,
        MAC2 = 3'd4,
        ACT  = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t state, state_next;

    logic                     all_v, all_q, start;
    logic signed [DATA_W-1:0] xa, xb, xc, wa, wb, wc;
    logic signed [DATA_W-1:0] mul_a, mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc, shifted;
    logic signed [DATA_W-1:0] sat_res, act_res;

    // Start fires only on the joint rising edge of the valid levels, and only when idle
    assign all_v = done1 & done2 & done3;
    assign start = all_v & ~all_q & (state == IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one state per cycle once started
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = MAC0;
            MAC0:    state_next = MAC1;
            MAC1:    state_next = MAC2;
            MAC2:    state_next = ACT;
            ACT:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared multiplier operand select
    always_comb begin
        mul_a = xa;
        mul_b = wa;
        case (state)
            MAC1: begin
                mul_a = xb;
                mul_b = wb;
            end
            MAC2: begin
                mul_a = xc;
                mul_b = wc;
            end
            default: ;
        endcase
    end

    assign prod = PROD_W'(mul_a) * PROD_W'(mul_b);

    // Rescale, saturate, activate
    always_comb begin
        shifted = acc >>> FRAC_W;
        if (shifted > SAT_MAX) begin
            sat_res = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_res = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_res = shifted[DATA_W-1:0];
        end
`ifdef DNN_NEURON_RELU_EN
        act_res = sat_res[DATA_W-1] ? '0 : sat_res;
`else
        act_res = sat_res;
`endif
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            all_q       <= 1'b0;
            y           <= '0;
            neuron_done <= 1'b0;
            ready       <= 1'b1;
            acc         <= '0;
            xa          <= '0;
            xb          <= '0;
            xc          <= '0;
            wa          <= '0;
            wb          <= '0;
            wc          <= '0;
        end else begin
            all_q       <= all_v;
            neuron_done <= (state_next == DONE);
            ready       <= (state_next == IDLE);
            case (state)
                LOAD: begin
                    // Latching one cycle after the edge also captures a weight written with the last flag
                    xa  <= x1;
                    xb  <= x2;
                    xc  <= x3;
                    wa  <= w1;
                    wb  <= w2;
                    wc  <= w3;
                    acc <= '0;
                end
                MAC0, MAC1, MAC2: acc <= acc + ACC_W'(prod);
                ACT:              y   <= act_res;
                default: ;
            endcase
        end
    end

endmodule
